// File: rtl/axi_credit_tx_pkg.sv
// Shared constants for the short AXI-stream FIFO family. The transmitter and
// the remote FIFO both take their depth from here so the credit pool always
// matches the space available at the far end.
package axi_credit_tx_pkg;

    // Depth of the default short FIFO, which is also the initial credit pool.
    localparam int SHORT_FIFO_DEPTH = 32;

    // Counter width needed to hold the value SHORT_FIFO_DEPTH itself.
    localparam int SHORT_FIFO_CW = 6;

endpackage

// File: rtl/axi_credit_counter.sv
// Saturating up/down credit counter with a sticky overflow flag.
// It decrements by one on dec and adds inc in the same cycle. A total above
// CREDITS clamps to CREDITS and raises overflow until reset or clear.
module axi_credit_counter
    import axi_credit_tx_pkg::*;
#(
    parameter int CREDITS = SHORT_FIFO_DEPTH,
    parameter int CW      = SHORT_FIFO_CW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          dec,
    input  logic [CW-1:0] inc,
    output logic [CW-1:0] count,
    output logic          overflow
);

    localparam logic [CW:0]   LIMIT = (CW + 1)'(CREDITS);
    localparam logic [CW-1:0] FULL  = CW'(CREDITS);

    logic [CW:0] sum;

    // Combined update, computed one bit wider so an over-return is visible.
    always_comb begin
        sum = {1'b0, count} - {{CW{1'b0}}, dec} + {1'b0, inc};
    end

    // Register the count, clamping at the pool size and latching overflow.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count    <= FULL;
            overflow <= 1'b0;
        end else if (sum > LIMIT) begin
            count    <= FULL;
            overflow <= 1'b1;
        end else begin
            count    <= sum[CW-1:0];
        end
    end

endmodule

// File: rtl/axi_credit_tx.sv
// Credit-based AXI4-Stream transmitter. It forwards words from a local
// producer onto a link that ends in a remote short FIFO. A word is accepted
// only when a credit is available. The credit is spent when the word enters
// the output register, so every word on the link already has space reserved
// at the far end.
module axi_credit_tx
    import axi_credit_tx_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int CREDITS = SHORT_FIFO_DEPTH,
    parameter int CW      = SHORT_FIFO_CW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [WIDTH-1:0] i_tdata,
    input  logic             i_tvalid,
    output logic             i_tready,
    output logic [WIDTH-1:0] o_tdata,
    output logic             o_tvalid,
    input  logic             o_tready,
    input  logic [CW-1:0]    cr_tdata,
    input  logic             cr_tvalid,
    output logic [CW-1:0]    credits,
    output logic             overflow
);

    logic          take;
    logic [CW-1:0] ret;

    // Accept a word when a credit is in hand and the output register is free or draining.
    always_comb begin
        i_tready = (credits != '0) && (!o_tvalid || o_tready);
        take     = i_tvalid && i_tready;
        ret      = cr_tvalid ? cr_tdata : '0;
    end

    // Output register: load on accept, empty after a link handshake, hold while stalled.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            o_tvalid <= 1'b0;
            o_tdata  <= '0;
        end else if (take) begin
            o_tvalid <= 1'b1;
            o_tdata  <= i_tdata;
        end else if (o_tready) begin
            o_tvalid <= 1'b0;
        end
    end

    axi_credit_counter #(
        .CREDITS (CREDITS),
        .CW      (CW)
    ) u_counter (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .dec      (take),
        .inc      (ret),
        .count    (credits),
        .overflow (overflow)
    );

endmodule

// File: tb/tb_axi_credit_tx.sv
// Self-checking bench for axi_credit_tx. A reference model that runs on the
// negative edge predicts ready, valid, credits and overflow from the credit
// rules and pushes each accepted word into a scoreboard queue. A separate
// monitor pops the queue on every link handshake and compares the data.
module tb_axi_credit_tx;

    localparam int WIDTH   = 32;
    localparam int CREDITS = 32;
    localparam int CW      = 6;

    logic             clk = 1'b0;
    logic             reset;
    logic             clear;
    logic [WIDTH-1:0] i_tdata;
    logic             i_tvalid;
    logic             i_tready;
    logic [WIDTH-1:0] o_tdata;
    logic             o_tvalid;
    logic             o_tready;
    logic [CW-1:0]    cr_tdata;
    logic             cr_tvalid;
    logic [CW-1:0]    credits;
    logic             overflow;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [WIDTH-1:0] exp_q[$];
    int  m_credits   = CREDITS;
    bit  m_overflow  = 1'b0;
    bit  model_ok    = 1'b0;
    int  delivered   = 0;
    int  remote_owed = 0;

    axi_credit_tx #(
        .WIDTH   (WIDTH),
        .CREDITS (CREDITS),
        .CW      (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .i_tdata   (i_tdata),
        .i_tvalid  (i_tvalid),
        .i_tready  (i_tready),
        .o_tdata   (o_tdata),
        .o_tvalid  (o_tvalid),
        .o_tready  (o_tready),
        .cr_tdata  (cr_tdata),
        .cr_tvalid (cr_tvalid),
        .credits   (credits),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge, then wait for the next edge.
    task automatic applyStimulus(input bit tv, input logic [WIDTH-1:0] td, input bit tr,
                                 input bit cv, input int cd, input bit clr);
        i_tvalid  = tv;
        i_tdata   = td;
        o_tready  = tr;
        cr_tvalid = cv;
        cr_tdata  = CW'(cd);
        clear     = clr;
        @(posedge clk);
        #1;
    endtask

    // Reference model: predict this cycle's outputs and the state after the next edge.
    always @(negedge clk) begin
        if (reset || clear) begin
            exp_q.delete();
            m_credits  = CREDITS;
            m_overflow = 1'b0;
            model_ok   = 1'b1;
        end else if (model_ok) begin
            bit word_held;
            bit exp_ready;
            bit take;
            int nxt;
            word_held = (exp_q.size() != 0);
            exp_ready = (m_credits > 0) && (!word_held || o_tready);
            checkOutput("i_tready", {63'd0, i_tready}, {63'd0, exp_ready});
            checkOutput("o_tvalid", {63'd0, o_tvalid}, {63'd0, word_held});
            checkOutput("credits", {58'd0, credits}, 64'(m_credits));
            checkOutput("overflow", {63'd0, overflow}, {63'd0, m_overflow});
            take = i_tvalid && exp_ready;
            if (take) exp_q.push_back(i_tdata);
            nxt = m_credits - (take ? 1 : 0) + (cr_tvalid ? int'(cr_tdata) : 0);
            if (nxt > CREDITS) begin
                m_credits  = CREDITS;
                m_overflow = 1'b1;
            end else begin
                m_credits  = nxt;
            end
        end
    end

    // Monitor: compare every delivered word and confirm stalled words hold still.
    always @(negedge clk) begin
        static bit               prev_stall = 1'b0;
        static logic [WIDTH-1:0] prev_data  = '0;
        #1;
        if (!reset && !clear && model_ok) begin
            if (prev_stall) begin
                checkOutput("hold_valid", {63'd0, o_tvalid}, 64'd1);
                checkOutput("hold_data", {32'd0, o_tdata}, {32'd0, prev_data});
            end
            if (o_tvalid && o_tready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_word", {32'd0, o_tdata}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    checkOutput("o_tdata", {32'd0, o_tdata}, {32'd0, exp_q.pop_front()});
                end
                delivered++;
                remote_owed++;
            end
            prev_stall = o_tvalid && !o_tready;
            prev_data  = o_tdata;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        int base;
        reset = 1'b1;
        clear = 1'b0;
        i_tvalid = 1'b0; i_tdata = '0; o_tready = 1'b0; cr_tvalid = 1'b0; cr_tdata = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("reset_tdata", {32'd0, o_tdata}, 64'd0);

        // Stream 40 words with no returns: exactly 32 get through.
        base = delivered;
        for (int i = 0; i < 40; i++) applyStimulus(1, $urandom, 1, 0, 0, 0);
        checkOutput("burst_words", 64'(delivered - base), 64'd32);

        // Return 5 credits while stalled, then exactly 5 more words pass.
        applyStimulus(1, $urandom, 1, 1, 5, 0);
        base = delivered;
        for (int i = 0; i < 10; i++) applyStimulus(1, $urandom, 1, 0, 0, 0);
        checkOutput("refill_words", 64'(delivered - base), 64'd5);

        // One credit back, then a take and a return in the same cycle.
        applyStimulus(0, 0, 1, 1, 1, 0);
        applyStimulus(1, $urandom, 1, 1, 1, 0);

        // Link stalled for 10 cycles with a word held, then drain.
        for (int i = 0; i < 10; i++) applyStimulus(1, $urandom, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) applyStimulus(0, 0, 1, 0, 0, 0);

        // From 30 credits, an over-return saturates and sets overflow until clear.
        applyStimulus(0, 0, 1, 0, 0, 1);
        for (int i = 0; i < 2; i++) applyStimulus(1, $urandom, 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 1, 5, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 1, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 1);
        applyStimulus(0, 0, 1, 0, 0, 0);

        // Leave 7 credits with a word held on the link, then clear mid-transfer.
        for (int i = 0; i < 25; i++) applyStimulus(1, $urandom, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1);
        remote_owed = 0;
        applyStimulus(0, 0, 1, 0, 0, 0);

        // Random traffic with a well-behaved remote end returning what it received.
        for (int i = 0; i < 3000; i++) begin
            bit clr;
            bit cv;
            int cd;
            clr = ($urandom_range(0, 299) == 0);
            cv  = 1'b0;
            cd  = 0;
            if (!clr && $urandom_range(0, 2) == 0) begin
                cv = 1'b1;
                if (remote_owed > 0 && $urandom_range(0, 4) != 0) begin
                    cd = $urandom_range(1, remote_owed);
                    remote_owed -= cd;
                end
            end
            applyStimulus($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) != 0, cv, cd, clr);
            if (clr) remote_owed = 0;
        end

        // Drain whatever is left and confirm every accepted word came out.
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 0, 0, 0);
        checkOutput("drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
